instr_issue_queue: RTL and testbench
====================================

Name: instr_issue_queue

Overview:
- Upstream feeder for the matrix-unit control FSM.
- Buffers 8-bit host instructions in a small FIFO and presents them one at a time on host_instruction.
- Presents the next instruction only when the FSM is idle, holds it until the FSM acknowledges by raising busy, then drives a do-nothing opcode so the instruction cannot be re-decoded.
- Discards do-nothing opcodes locally and flags FSMs that never acknowledge.

Parameters:
DEPTH, 8, FIFO entries (power of two, at least 2)
INSTR_W, 8, instruction width
BUSY_TIMEOUT, 4, cycles to wait in ISSUE for fsm_busy before abandoning the instruction

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
host_wr_en  in  1  host write strobe
host_wr_data  in  INSTR_W  instruction written by host, format {DD[1:0],AA[1:0],op[3:0]}
flush  in  1  synchronous FIFO clear
fsm_busy  in  1  busy output of the control FSM
host_instruction  out  INSTR_W  registered instruction to the FSM
issue  out  1  one-cycle pulse when an instruction is popped for issue
nop_drop  out  1  one-cycle pulse when a do-nothing opcode is popped and discarded
wr_drop  out  1  one-cycle pulse when a host write is rejected because the FIFO is full
err_timeout  out  1  sticky; set on ISSUE timeout, cleared only by reset
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  log2(DEPTH)+1  number of stored entries

Behaviour:
- Reset values: host_instruction=0, issue=0, nop_drop=0, wr_drop=0, err_timeout=0, count=0, empty=1, full=0, state=IDLE.
- Reset is honoured mid-operation: any in-flight instruction is lost and host_instruction returns to 0 immediately.
- FIFO write: on host_wr_en with !full, store host_wr_data.
  - Write while full: data discarded, wr_drop=1, even if a pop occurs in the same cycle.
  - full uses the pre-edge count.
- FIFO bypass: none. A write into an empty FIFO is first eligible for pop on the next cycle, so write-to-issue latency is at least 2 cycles.
- Simultaneous write and pop (not full): count unchanged.
- Pointers wrap modulo DEPTH.
- flush: sets count=0 and pointers=0.
  - A write in the same cycle as flush is discarded, with no wr_drop.
  - The state machine and host_instruction are unaffected.
- A do-nothing opcode is any value with bits[3:2]==2'b00.
- State machine, registered, one transition per cycle:
  - IDLE, with !empty and !fsm_busy:
    - Head is do-nothing: pop, nop_drop=1, stay IDLE, host_instruction stays 0.
    - Otherwise: pop, host_instruction<=head, issue=1, clear timeout counter, go to ISSUE.
  - IDLE, empty or fsm_busy: hold, host_instruction=0.
  - ISSUE: hold host_instruction.
    - fsm_busy=1: host_instruction<=0, go to WAIT_DONE.
    - Otherwise, when the timeout counter reaches BUSY_TIMEOUT-1: err_timeout<=1, host_instruction<=0, go to IDLE. The instruction is dropped and never retried.
    - Otherwise: increment the counter.
  - WAIT_DONE: host_instruction=0. fsm_busy=0 returns to IDLE; the next pop can occur in the cycle after that return.
- host_instruction is 0 in every state except ISSUE.
- issue and nop_drop are mutually exclusive.
- At most one pop per cycle.

Decomposition:
- Shared package (mpu_ctrl_pkg):
  - opcode constants: LOAD 4'b0100, COPY 4'b0101, UNLOAD 4'b0110, CLEAR 4'b0111, ADD 4'b1100, SHIFT 4'b1101, SUB 4'b1110, MULT 4'b1111
  - NOP_INSTR 8'h00
  - is_nop function on bits[3:2]
  - issue state encoding
- One sub-module, instr_fifo: a parameterised synchronous FIFO with count, full, empty and flush. The issue FSM stays in the top level.

Test Plan:
- Single issue: write 8'h4C (ADD, DD=01, AA=00) into an empty queue, FSM model raises busy 2 cycles after host_instruction changes, holds it 3 cycles -> issue pulse exactly once; host_instruction=8'h4C from pop+1 until busy is seen, then 8'h00; next pop only after busy falls.
- NOP discard: queue 8'hF0, 8'h07 (CLEAR) -> nop_drop on the first pop, 8'h07 issued on the next IDLE cycle, 8'hF0 never appears on host_instruction.
- Full/overflow: 9 writes with fsm_busy held at 1 (DEPTH=8) -> full=1 and count=8 after the 8th write, wr_drop on the 9th; issue order matches write order and the 9th value is never issued.
- Timeout: issue 8'h0F with fsm_busy held at 0 -> after 4 cycles in ISSUE, err_timeout=1 (sticky), host_instruction=0, the next entry issues normally.
- Flush and reset: 5 entries queued, one instruction in WAIT_DONE, assert flush -> count=0 and the in-flight transaction completes. Then assert reset mid-ISSUE -> all outputs at reset values the same cycle, err_timeout cleared.

Source files
------------

// File: rtl/mpu_ctrl_pkg.sv
// Shared definitions for the matrix-unit control path: opcodes, the
// do-nothing instruction, the issue FSM state type and the do-nothing decode.
package mpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LOAD   = 4'b0100,
    OP_COPY   = 4'b0101,
    OP_UNLOAD = 4'b0110,
    OP_CLEAR  = 4'b0111,
    OP_ADD    = 4'b1100,
    OP_SHIFT  = 4'b1101,
    OP_SUB    = 4'b1110,
    OP_MULT   = 4'b1111
  } opcode_e;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } issue_state_e;

  // Any opcode whose class bits [3:2] are zero does nothing in the control FSM.
  function automatic logic is_nop(input logic [3:0] op);
    return (op & 4'b1100) == 4'b0000;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy count, registered full/empty and a
// synchronous flush that drops any same-cycle write.
module instr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rd_data_c_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             wr_ok, rd_ok;

  assign wr_ok = wr_en_i & ~full_q & ~flush_i;
  assign rd_ok = rd_en_i & ~empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_c_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers host instructions and hands them one at a time to the matrix-unit
// control FSM, waiting for its busy acknowledge before presenting the next.
module instr_issue_queue
  import mpu_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned INSTR_W      = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_wr_en,
  input  logic [INSTR_W-1:0]       host_wr_data,
  input  logic                     flush,
  input  logic                     fsm_busy,
  output logic [INSTR_W-1:0]       host_instruction,
  output logic                     issue,
  output logic                     nop_drop,
  output logic                     wr_drop,
  output logic                     err_timeout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  issue_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               issue_q, issue_d;
  logic               nop_drop_q, nop_drop_d;
  logic               wr_drop_q, wr_drop_d;
  logic               err_q, err_d;
  logic               pop;
  logic [INSTR_W-1:0] head;
  logic               fifo_full, fifo_empty;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (host_wr_en),
    .wr_data_i   (host_wr_data),
    .rd_en_i     (pop),
    .flush_i     (flush),
    .rd_data_c_o (head),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    issue_d    = 1'b0;
    nop_drop_d = 1'b0;
    pop        = 1'b0;
    wr_drop_d  = host_wr_en & fifo_full & ~flush;
    unique case (state_q)
      ST_IDLE: begin
        instr_d = INSTR_W'(NOP_INSTR);
        if (!fifo_empty && !fsm_busy) begin
          pop = 1'b1;
          if (is_nop(head[3:0])) begin
            nop_drop_d = 1'b1;
          end else begin
            instr_d = head;
            issue_d = 1'b1;
            tmo_d   = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // An unacknowledged instruction is abandoned, not retried.
        if (fsm_busy) begin
          instr_d = INSTR_W'(NOP_INSTR);
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          instr_d = INSTR_W'(NOP_INSTR);
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        instr_d = INSTR_W'(NOP_INSTR);
        if (!fsm_busy) state_d = ST_IDLE;
      end
      default: begin
        instr_d = INSTR_W'(NOP_INSTR);
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      tmo_q      <= '0;
      issue_q    <= 1'b0;
      nop_drop_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      tmo_q      <= tmo_d;
      issue_q    <= issue_d;
      nop_drop_q <= nop_drop_d;
      wr_drop_q  <= wr_drop_d;
      err_q      <= err_d;
    end
  end

  assign host_instruction = instr_q;
  assign issue            = issue_q;
  assign nop_drop         = nop_drop_q;
  assign wr_drop          = wr_drop_q;
  assign err_timeout      = err_q;
  assign full             = fifo_full;
  assign empty            = fifo_empty;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed and randomized checks of instr_issue_queue against a queue-based
// reference model of the issue protocol.
module tb_instr_issue_queue;

  localparam int unsigned DEPTH        = 8;
  localparam int unsigned INSTR_W      = 8;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned CW           = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               host_wr_en;
  logic [INSTR_W-1:0] host_wr_data;
  logic               flush;
  logic               fsm_busy;
  logic [INSTR_W-1:0] host_instruction;
  logic               issue, nop_drop, wr_drop, err_timeout, full, empty;
  logic [CW-1:0]      count;

  always #5 clk = ~clk;

  instr_issue_queue #(
    .DEPTH        (DEPTH),
    .INSTR_W      (INSTR_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .host_wr_en       (host_wr_en),
    .host_wr_data     (host_wr_data),
    .flush            (flush),
    .fsm_busy         (fsm_busy),
    .host_instruction (host_instruction),
    .issue            (issue),
    .nop_drop         (nop_drop),
    .wr_drop          (wr_drop),
    .err_timeout      (err_timeout),
    .full             (full),
    .empty            (empty),
    .count            (count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: stored entries, what is on the wire, and protocol phase.
  logic [7:0] mq[$];
  bit         m_presenting;   // instruction on the wire, awaiting busy
  bit         m_acked;        // FSM acknowledged, waiting for busy to drop
  int         m_age;          // non-busy cycles spent presenting
  logic [7:0] m_instr;
  bit         m_issue, m_nop, m_wdrop, m_err;
  int         issued_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_presenting = 0; m_acked = 0; m_age = 0;
    m_instr = 8'h00; m_issue = 0; m_nop = 0; m_wdrop = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit was_full;
    bit took;
    logic [7:0] h;
    was_full = (mq.size() == DEPTH);
    took     = 0;
    m_issue  = 0;
    m_nop    = 0;
    m_wdrop  = host_wr_en && was_full && !flush;
    if (m_presenting) begin
      if (fsm_busy) begin
        m_presenting = 0; m_acked = 1; m_instr = 8'h00;
      end else begin
        m_age = m_age + 1;
        if (m_age == BUSY_TIMEOUT) begin
          m_presenting = 0; m_err = 1; m_instr = 8'h00;
        end
      end
    end else if (m_acked) begin
      if (!fsm_busy) m_acked = 0;
    end else if (mq.size() > 0 && !fsm_busy) begin
      took = 1;
      h = mq[0];
      if (h[3:2] == 2'b00) m_nop = 1;
      else begin
        m_presenting = 1; m_age = 0; m_instr = h; m_issue = 1; issued_cnt++;
      end
    end
    if (took) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (host_wr_en && !was_full) mq.push_back(host_wr_data);
  endtask

  task automatic check_all();
    chk("host_instruction", 32'(host_instruction), 32'(m_instr));
    chk("issue",       32'(issue),       32'(m_issue));
    chk("nop_drop",    32'(nop_drop),    32'(m_nop));
    chk("wr_drop",     32'(wr_drop),     32'(m_wdrop));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("count",       32'(count),       32'(mq.size()));
    chk("full",        32'(full),        32'(mq.size() == DEPTH));
    chk("empty",       32'(empty),       32'(mq.size() == 0));
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd, input logic fl, input logic bz);
    host_wr_en = we; host_wr_data = wd; flush = fl; fsm_busy = bz;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    host_wr_en = 0; host_wr_data = 8'h00; flush = 0; fsm_busy = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    issued_cnt = 0;
    reset = 1'b0;
    #2;
    do_reset();

    // Single issue of ADD, acknowledged 2 cycles later and held 3 cycles
    cyc(1, 8'h4C, 0, 0);
    chk("single_no_bypass", 32'(host_instruction), 32'h00);
    cyc(0, 8'h00, 0, 0);
    chk("single_issue_val", 32'(host_instruction), 32'h4C);
    cyc(0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 1);
    chk("single_after_busy", 32'(host_instruction), 32'h00);
    for (int i = 0; i < 2; i++) cyc(0, 8'h00, 0, 0);

    // Do-nothing opcode discarded, CLEAR issued next
    cyc(1, 8'hF0, 0, 0);
    cyc(1, 8'h07, 0, 0);
    chk("nop_pulse", 32'(nop_drop), 32'h1);
    cyc(0, 8'h00, 0, 0);
    chk("clear_issued", 32'(host_instruction), 32'h07);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);

    // Overflow: 9 writes with busy held
    for (int i = 0; i < 9; i++) begin
      cyc(1, 8'(8'h40 + 8'(i) * 8'h11), 0, 1);
      if (i == 7) begin
        chk("full_at_8", 32'(full), 32'h1);
        chk("count_at_8", 32'(count), 32'd8);
      end
    end
    chk("wr_drop_9th", 32'(wr_drop), 32'h1);
    for (int i = 0; i < 30; i++) cyc(0, 8'h00, 0, m_presenting);
    chk("drained", 32'(empty), 32'h1);

    // Timeout on an unacknowledged instruction, then normal issue
    cyc(1, 8'h0F, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0);
    chk("timeout_sticky", 32'(err_timeout), 32'h1);
    cyc(1, 8'h4D, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("post_timeout_issue", 32'(host_instruction), 32'h4D);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);

    // Flush while an instruction is in WAIT_DONE
    cyc(1, 8'h41, 0, 0);
    cyc(0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + 8'(i)), 0, 1);
    chk("five_queued", 32'(count), 32'd5);
    cyc(1, 8'h77, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    cyc(0, 8'h00, 0, 0);

    // Reset while an instruction is being presented
    cyc(1, 8'h4E, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("pre_reset_issue", 32'(host_instruction), 32'h4E);
    do_reset();
    chk("reset_err_clear", 32'(err_timeout), 32'h0);

    // Randomized traffic with a random busy pattern and occasional flush
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 40) == 0),
          1'($urandom_range(0, 2) == 0));
      if (i == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
